// File: rtl/stripe_block_buf_if.sv
// Bus bundle for stripe_block_buf: raster pixel input and block-ordered pixel output.
// The slave modport is the buffer's view; the master modport is the source/sink side.
interface stripe_block_buf_if #(
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_W-1:0]              in_data;
    logic                           in_sof;
    logic                           order_sel;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_W-1:0]              out_data;
    logic                           out_sob;
    logic                           out_eob;
    logic                           out_eos;
    logic [$clog2(NUM_BANKS+1)-1:0] banks_full;

    modport master (
        output in_valid, in_data, in_sof, order_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sob, out_eob, out_eos, banks_full
    );

    modport slave (
        input  in_valid, in_data, in_sof, order_sel, out_ready,
        output in_ready, out_valid, out_data, out_sob, out_eob, out_eos, banks_full
    );
endinterface

// File: rtl/stripe_block_buf.sv
// Multi-bank stripe buffer: collects BLK_H raster lines per bank and replays each
// full stripe as BLK_W x BLK_H blocks (row- or column-major) through a 2-stage read pipe.
module stripe_block_buf #(
    parameter int WIDTH     = 1280,
    parameter int BLK_W     = 8,
    parameter int BLK_H     = 8,
    parameter int NUM_BANKS = 2,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    stripe_block_buf_if.slave bus
);
    localparam int XB    = $clog2(WIDTH);
    localparam int LB    = $clog2(BLK_H);
    localparam int CB    = $clog2(BLK_W);
    localparam int NBLK  = WIDTH / BLK_W;
    localparam int BB    = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int KB    = $clog2(NUM_BANKS);
    localparam int CW    = $clog2(NUM_BANKS + 1);
    localparam int AW    = LB + XB;
    localparam int DEPTH = 1 << AW;

    generate
        if ((WIDTH % BLK_W) != 0 || BLK_W < 2 || BLK_H < 2 || NUM_BANKS < 2 ||
            (BLK_W & (BLK_W - 1)) != 0 || (BLK_H & (BLK_H - 1)) != 0) begin : g_param_check
            $error("stripe_block_buf: invalid WIDTH/BLK_W/BLK_H/NUM_BANKS combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    // ---------------- write side ----------------
    logic [XB-1:0]        r_wr_x;
    logic [LB-1:0]        r_wr_line;
    logic [KB-1:0]        r_wr_bank;
    logic [KB-1:0]        r_rd_bank;
    logic [NUM_BANKS-1:0] r_full;
    logic [CW-1:0]        r_banks_full;
    logic                 w_in_fire;
    logic [XB-1:0]        w_x;
    logic [LB-1:0]        w_line;
    logic                 w_wr_last;
    logic [AW-1:0]        w_waddr;
    logic                 w_drain_done;

    assign bus.in_ready = ~r_full[r_wr_bank];
    assign w_in_fire    = bus.in_valid & bus.in_ready;
    assign w_x          = bus.in_sof ? '0 : r_wr_x;
    assign w_line       = bus.in_sof ? '0 : r_wr_line;
    assign w_wr_last    = w_in_fire && (w_x == XB'(WIDTH - 1)) && (w_line == LB'(BLK_H - 1));
    assign w_waddr      = {w_line, w_x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_x    <= '0;
            r_wr_line <= '0;
            r_wr_bank <= '0;
        end else if (w_in_fire) begin
            // line is a power-of-two counter, so it wraps at BLK_H-1 on its own
            if (w_x == XB'(WIDTH - 1)) begin
                r_wr_x    <= '0;
                r_wr_line <= w_line + 1'b1;
            end else begin
                r_wr_x    <= w_x + 1'b1;
                r_wr_line <= w_line;
            end
            if (w_wr_last)
                r_wr_bank <= (r_wr_bank == KB'(NUM_BANKS - 1)) ? '0 : r_wr_bank + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= '0;
            r_banks_full <= '0;
        end else begin
            if (w_wr_last)    r_full[r_wr_bank] <= 1'b1;
            if (w_drain_done) r_full[r_rd_bank] <= 1'b0;
            case ({w_wr_last, w_drain_done})
                2'b10:   r_banks_full <= r_banks_full + 1'b1;
                2'b01:   r_banks_full <= r_banks_full - 1'b1;
                default: r_banks_full <= r_banks_full;
            endcase
        end
    end

    assign bus.banks_full = r_banks_full;

    // ---------------- read side ----------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_order;
    logic [BB-1:0]     r_rd_b;
    logic [LB-1:0]     r_rd_r;
    logic [CB-1:0]     r_rd_c;
    logic              w_en;
    logic              w_start;
    logic              w_issue;
    logic              w_c_last;
    logic              w_r_last;
    logic              w_sob;
    logic              w_blk_last;
    logic              w_scan_last;
    logic [AW-1:0]     w_raddr;
    logic              r_s1_valid;
    logic              r_s1_sob;
    logic              r_s1_eob;
    logic              r_s1_eos;
    logic [KB-1:0]     r_s1_bank;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sob;
    logic              r_out_eob;
    logic              r_out_eos;
    logic [DATA_W-1:0] w_q [NUM_BANKS];

    assign w_en        = ~r_out_valid | bus.out_ready;
    assign w_c_last    = (r_rd_c == CB'(BLK_W - 1));
    assign w_r_last    = (r_rd_r == LB'(BLK_H - 1));
    assign w_sob       = (r_rd_c == '0) && (r_rd_r == '0);
    assign w_blk_last  = w_c_last && w_r_last;
    assign w_scan_last = w_blk_last && (r_rd_b == BB'(NBLK - 1));
    assign w_raddr     = {r_rd_r, XB'({r_rd_b, r_rd_c})};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_en) begin
                    w_issue = 1'b1;
                    if (w_scan_last) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_out_valid && bus.out_ready && r_out_eos) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_order   <= 1'b0;
            r_rd_b    <= '0;
            r_rd_r    <= '0;
            r_rd_c    <= '0;
            r_rd_bank <= '0;
        end else begin
            if (w_start) begin
                r_order <= bus.order_sel;
                r_rd_b  <= '0;
                r_rd_r  <= '0;
                r_rd_c  <= '0;
            end else if (w_issue) begin
                // r/c are power-of-two counters; carry moves to the outer index
                if (!r_order) begin
                    r_rd_c <= r_rd_c + 1'b1;
                    if (w_c_last) r_rd_r <= r_rd_r + 1'b1;
                end else begin
                    r_rd_r <= r_rd_r + 1'b1;
                    if (w_r_last) r_rd_c <= r_rd_c + 1'b1;
                end
                if (w_blk_last)
                    r_rd_b <= (r_rd_b == BB'(NBLK - 1)) ? '0 : r_rd_b + 1'b1;
            end
            if (w_drain_done)
                r_rd_bank <= (r_rd_bank == KB'(NUM_BANKS - 1)) ? '0 : r_rd_bank + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk) begin
            if (w_in_fire && (r_wr_bank == KB'(g))) r_mem[w_waddr] <= bus.in_data;
            if (w_issue && (r_rd_bank == KB'(g)))   r_q <= r_mem[w_raddr];
        end
        assign w_q[g] = r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sob    <= 1'b0;
            r_s1_eob    <= 1'b0;
            r_s1_eos    <= 1'b0;
            r_s1_bank   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sob   <= 1'b0;
            r_out_eob   <= 1'b0;
            r_out_eos   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= w_issue;
            r_s1_sob    <= w_issue & w_sob;
            r_s1_eob    <= w_issue & w_blk_last;
            r_s1_eos    <= w_issue & w_scan_last;
            r_s1_bank   <= r_rd_bank;
            r_out_valid <= r_s1_valid;
            r_out_data  <= w_q[r_s1_bank];
            r_out_sob   <= r_s1_sob;
            r_out_eob   <= r_s1_eob;
            r_out_eos   <= r_s1_eos;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sob   = r_out_sob;
    assign bus.out_eob   = r_out_eob;
    assign bus.out_eos   = r_out_eos;
endmodule

// File: tb/tb_stripe_block_buf.sv
// Scoreboard bench for stripe_block_buf: a raster-array reference model predicts
// block-ordered output; a monitor thread pops and compares on each output handshake.
module tb_stripe_block_buf;
    localparam int W    = 16;
    localparam int BW   = 8;
    localparam int BH   = 8;
    localparam int NB   = 2;
    localparam int DW   = 16;
    localparam int NBLK = W / BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stripe_block_buf_if #(.DATA_W(DW), .NUM_BANKS(NB)) bus ();

    stripe_block_buf #(
        .WIDTH(W), .BLK_W(BW), .BLK_H(BH), .NUM_BANKS(NB), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sob;
        logic          eob;
        logic          eos;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] pix [BH][W];
    int n_checks = 0, n_fail = 0;
    int n_done = 0, n_drained = 0, n_acc = 0, n_pop = 0;
    int mx = 0, mline = 0;
    bit m_order = 1'b0;
    int ready_mode = 0;
    bit in_rst = 1'b1;
    int cyc = 0, pos_in_stripe = 0, t_sos = 0, stripe_span = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected replay of the stripe just captured, straight from block geometry.
    function automatic void push_stripe();
        exp_t e;
        int r, c;
        for (int b = 0; b < NBLK; b++) begin
            for (int o = 0; o < BH * BW; o++) begin
                if (!m_order) begin r = o / BW; c = o % BW; end
                else          begin c = o / BH; r = o % BH; end
                e.d   = pix[r][b * BW + c];
                e.sob = (r == 0 && c == 0);
                e.eob = (r == BH - 1 && c == BW - 1);
                e.eos = e.eob && (b == NBLK - 1);
                sb.push_back(e);
            end
        end
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit sof);
        if (sof) begin mx = 0; mline = 0; end
        pix[mline][mx] = d;
        n_acc++;
        if (mx == W - 1) begin
            mx = 0;
            if (mline == BH - 1) begin
                mline = 0;
                n_done++;
                push_stripe();
            end else begin
                mline++;
            end
        end else begin
            mx++;
        end
    endtask

    task automatic send_pix(input logic [DW-1:0] d, input bit sof);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        while (!bus.in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, sof);
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_ramp(input int base, input bit sof0);
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < W; x++)
                send_pix(DW'(base + y * W + x), sof0 && y == 0 && x == 0);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) idle_in();
            send_pix(DW'($urandom), 1'b0);
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((sb.size() != 0 || bus.banks_full != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_queue_empty"}, sb.size(), 0);
        check({name, "_banks_empty"}, 32'(bus.banks_full), 0);
    endtask

    task automatic monitor_loop();
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        exp_t          e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_rst) begin
                prev_stall    = 1'b0;
                bus.out_ready = 1'b1;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.out_valid), 1);
                    check("stall_data", 32'(bus.out_data), 32'(prev_data));
                end
                check("banks_full", 32'(bus.banks_full), n_done - n_drained);
                case (ready_mode)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = ($urandom_range(9) < 3);
                    default: bus.out_ready = 1'b0;
                endcase
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(bus.out_valid), 0);
                    end else begin
                        e     = sb.pop_front();
                        a.d   = bus.out_data;
                        a.sob = bus.out_sob;
                        a.eob = bus.out_eob;
                        a.eos = bus.out_eos;
                        check("pixel{d,sob,eob,eos}", 32'(a), 32'(e));
                        n_pop++;
                        if (pos_in_stripe == 0) t_sos = cyc;
                        pos_in_stripe++;
                        if (e.eos) begin
                            n_drained++;
                            stripe_span   = cyc - t_sos;
                            pos_in_stripe = 0;
                        end
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    endtask

    initial begin
        int acc0, drained0, pop0, t;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.order_sel = 1'b0;
        fork
            monitor_loop();
            begin
                #500000;
                n_fail++;
                $display("FAIL watchdog: simulation time budget exceeded");
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_banks_full", 32'(bus.banks_full), 0);
        check("rst_flags", 32'({bus.out_sob, bus.out_eob, bus.out_eos}), 0);
        rst_n  = 1'b1;
        in_rst = 1'b0;

        // Row-major ramp, full rate: 128 handshakes on consecutive cycles
        ready_mode = 0; bus.order_sel = 1'b0; m_order = 1'b0;
        send_ramp(0, 1'b1);
        idle_in();
        wait_drain("rowmajor");
        check("rowmajor_span_no_bubble", stripe_span, BH * W - 1);

        // Column-major ramp
        bus.order_sel = 1'b1; m_order = 1'b1;
        send_ramp(0, 1'b0);
        idle_in();
        wait_drain("colmajor");

        // Random backpressure on the row-major ramp
        ready_mode = 1; bus.order_sel = 1'b0; m_order = 1'b0;
        send_ramp(0, 1'b0);
        idle_in();
        wait_drain("backpressure");
        ready_mode = 0;

        // Random data, random order, two stripes with input gaps
        m_order = 1'($urandom_range(1)); bus.order_sel = m_order;
        send_rand(2 * BH * W);
        idle_in();
        wait_drain("random");

        // Overrun throttle: sink stalled, three stripes offered
        ready_mode = 2; bus.order_sel = 1'b0; m_order = 1'b0;
        acc0 = n_acc; drained0 = n_drained;
        send_ramp(0, 1'b0);
        send_ramp(256, 1'b0);
        idle_in();
        repeat (10) @(negedge clk);
        check("overrun_in_ready_low", 32'(bus.in_ready), 0);
        check("overrun_banks_full", 32'(bus.banks_full), NB);
        check("overrun_accepted", n_acc - acc0, 2 * BH * W);
        fork
            send_ramp(512, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check("overrun_hold", n_acc - acc0, 2 * BH * W);
                ready_mode = 0;
                t = 0;
                while (n_acc - acc0 <= 2 * BH * W && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                check("stripe3_after_stripe1_drain", n_drained - drained0, 1);
            end
        join
        idle_in();
        wait_drain("overrun");

        // Mid-stripe sof discards the partial stripe
        send_rand(40);
        idle_in();
        repeat (5) @(negedge clk);
        check("partial_not_counted", 32'(bus.banks_full), 0);
        send_ramp(4096, 1'b1);
        idle_in();
        wait_drain("midsof");

        // Asynchronous reset while scanning
        pop0 = n_pop;
        send_ramp(8192, 1'b0);
        idle_in();
        t = 0;
        while (n_pop - pop0 < 20 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reset_reached_scan", 32'(n_pop - pop0 >= 20), 1);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_banks_full", 32'(bus.banks_full), 0);
        check("arst_in_ready", 32'(bus.in_ready), 1);
        check("arst_flags", 32'({bus.out_sob, bus.out_eob, bus.out_eos}), 0);
        sb.delete();
        n_done = 0; n_drained = 0; pos_in_stripe = 0; mx = 0; mline = 0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        bus.order_sel = 1'b1; m_order = 1'b1;
        send_ramp(12288, 1'b0);
        idle_in();
        wait_drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
